// File: rtl/ifetch_pkg.sv
// Shared widths, FSM encoding and address helpers for the copperv fetch stage.
package ifetch_pkg;

  localparam int PC_WIDTH          = 32;
  localparam int INST_WIDTH        = 32;
  localparam int FETCH_STATE_WIDTH = 2;

  typedef enum logic [FETCH_STATE_WIDTH-1:0] {
    FETCH_STATE_IDLE = 2'd0,
    FETCH_STATE_ADDR = 2'd1,
    FETCH_STATE_DATA = 2'd2,
    FETCH_STATE_HOLD = 2'd3
  } fetch_state_e;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] a);
    return a & ~PC_WIDTH'(3);
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch stage: one outstanding read on the instruction bus, word
// handed to the decoder with its PC, redirects from execute squash stale words.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ir_addr_valid,
  input  logic                  ir_addr_ready,
  output logic [PC_WIDTH-1:0]   ir_addr,
  input  logic                  ir_data_valid,
  output logic                  ir_data_ready,
  input  logic [INST_WIDTH-1:0] ir_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output fetch_state_e          state_o
);

  // Every channel transfers on a rising edge where valid and ready are both 1;
  // a producer holds valid and its payload stable until that edge.
  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  discard_q, discard_d;
  logic [PC_WIDTH-1:0]   addr_q, addr_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  data_ready_q, data_ready_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [PC_WIDTH-1:0]   redirect_target;

  assign redirect_target = word_align(redirect_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_STATE_IDLE;
      fetch_pc_q   <= RESET_ADDR;
      discard_q    <= 1'b0;
      addr_q       <= RESET_ADDR;
      addr_valid_q <= 1'b0;
      data_ready_q <= 1'b0;
      inst_q       <= '0;
      pc_q         <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      discard_q    <= discard_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      data_ready_q <= data_ready_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    discard_d    = discard_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    data_ready_d = data_ready_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;

    // A redirect always wins over the sequential pc+4 update below.
    if (redirect_valid) fetch_pc_d = redirect_target;

    case (state_q)
      FETCH_STATE_IDLE: begin
        state_d      = FETCH_STATE_ADDR;
        addr_valid_d = 1'b1;
        addr_d       = fetch_pc_d;
      end
      FETCH_STATE_ADDR: begin
        // The request already on the bus cannot be retracted; mark its reply stale.
        if (redirect_valid) discard_d = 1'b1;
        if (ir_addr_ready) begin
          state_d      = FETCH_STATE_DATA;
          addr_valid_d = 1'b0;
          data_ready_d = 1'b1;
        end
      end
      FETCH_STATE_DATA: begin
        if (ir_data_valid) begin
          data_ready_d = 1'b0;
          if (discard_q || redirect_valid) begin
            discard_d    = 1'b0;
            state_d      = FETCH_STATE_ADDR;
            addr_valid_d = 1'b1;
            addr_d       = fetch_pc_d;
          end else begin
            inst_d       = ir_data;
            pc_d         = addr_q;
            inst_valid_d = 1'b1;
            state_d      = FETCH_STATE_HOLD;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      FETCH_STATE_HOLD: begin
        if (redirect_valid || inst_ready) begin
          if (!redirect_valid) fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
          inst_valid_d = 1'b0;
          state_d      = FETCH_STATE_ADDR;
          addr_valid_d = 1'b1;
          addr_d       = fetch_pc_d;
        end
      end
      default: state_d = FETCH_STATE_IDLE;
    endcase
  end

  assign ir_addr_valid = addr_valid_q;
  assign ir_addr       = addr_q;
  assign ir_data_ready = data_ready_q;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign pc            = pc_q;
  assign state_o       = state_q;

endmodule
